// File: rtl/btn_debounce_ctrl.sv
// Button front-end for the 8-bit up-counter: synchronise, debounce and
// arbitrate the increment/clear buttons into one-cycle counter commands.

module btn_debounce_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic level_nxt,
    output logic press_nxt
);

    localparam int TW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    state_t                 state_d;
    logic [TW-1:0]          timer_q;
    logic [TW-1:0]          timer_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            level   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
            state_q <= state_d;
            timer_q <= timer_d;
            level   <= level_nxt;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_nxt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    timer_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (timer_q == TMAX) begin
                    state_d   = PRESSED;
                    press_nxt = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    timer_d = '0;
                end
            end
            RELEASE_WAIT: begin
                // A short dip back to pressed is a glitch, not a new press
                if (s) begin
                    state_d = PRESSED;
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        level_nxt = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

endmodule

module btn_debounce_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc,
    input  logic btn_clr,
    output logic cnt_en,
    output logic cnt_clr,
    output logic inc_level,
    output logic clr_level
);

    logic inc_press_nxt;
    logic clr_press_nxt;
    logic inc_level_nxt;
    logic clr_level_nxt;

    btn_debounce_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn_inc),
        .level    (inc_level),
        .level_nxt(inc_level_nxt),
        .press_nxt(inc_press_nxt)
    );

    btn_debounce_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn_clr),
        .level    (clr_level),
        .level_nxt(clr_level_nxt),
        .press_nxt(clr_press_nxt)
    );

    // Commands are built from next-state values so they line up with the levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
        end else begin
            cnt_clr <= clr_press_nxt;
            cnt_en  <= inc_press_nxt & ~clr_press_nxt & ~clr_level_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Outputs are compared 1 time unit after each rising edge.

module tb_btn_debounce_ctrl;

    typedef struct {
        bit       inc;
        bit       clr;
        bit [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_inc;
    logic btn_clr;
    logic cnt_en;
    logic cnt_clr;
    logic inc_level;
    logic clr_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    btn_debounce_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_inc  (btn_inc),
        .btn_clr  (btn_clr),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .inc_level(inc_level),
        .clr_level(clr_level)
    );

    task automatic add(input bit inc, input bit clr, input int n,
                       input bit [3:0] exp);
        vec_t v;
        v.inc = inc;
        v.clr = clr;
        v.exp = exp;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got en,clr,il,cl=%b required %b",
                     name, got, req);
        end
    endtask

    // Counts cnt_en pulses over 15 edges; exactly one is required, after edge 6
    task automatic count_pulse(input string name);
        int cnt;
        int at;
        cnt = 0;
        at  = -1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (cnt_en === 1'b1) begin
                cnt++;
                if (at < 0) at = k;
            end
        end
        n_checks++;
        if (cnt != 1 || at != 6) begin
            n_fail++;
            $display("FAIL %s: got %0d pulses first at edge %0d required 1 at edge 6",
                     name, cnt, at);
        end
    endtask

    function automatic logic [3:0] outs();
        return {cnt_en, cnt_clr, inc_level, clr_level};
    endfunction

    initial begin
        // idle
        add(0, 0, 3, 4'b0000);
        // 1: clean press and release
        add(1, 0, 6, 4'b0000);
        add(1, 0, 1, 4'b1010);
        add(1, 0, 13, 4'b0010);
        add(0, 0, 6, 4'b0010);
        add(0, 0, 6, 4'b0000);
        // 2: bounce 3 high / 1 low x3, then steady
        repeat (3) begin
            add(1, 0, 3, 4'b0000);
            add(0, 0, 1, 4'b0000);
        end
        add(1, 0, 6, 4'b0000);
        add(1, 0, 1, 4'b1010);
        add(1, 0, 5, 4'b0010);
        // 3: 2-cycle low glitch while held, then release
        add(0, 0, 2, 4'b0010);
        add(1, 0, 8, 4'b0010);
        add(0, 0, 6, 4'b0010);
        add(0, 0, 4, 4'b0000);
        // 4: simultaneous press
        add(1, 1, 6, 4'b0000);
        add(1, 1, 1, 4'b0111);
        add(1, 1, 5, 4'b0011);
        add(0, 0, 6, 4'b0011);
        add(0, 0, 4, 4'b0000);
        // 5: clear held, increment pressed 10 cycles later
        add(0, 1, 6, 4'b0000);
        add(0, 1, 1, 4'b0101);
        add(0, 1, 3, 4'b0001);
        add(1, 1, 6, 4'b0001);
        add(1, 1, 1, 4'b0011);
        add(1, 1, 4, 4'b0011);
        add(1, 0, 6, 4'b0011);
        add(1, 0, 3, 4'b0010);
        add(0, 0, 6, 4'b0010);
        add(0, 0, 4, 4'b0000);
        add(1, 0, 6, 4'b0000);
        add(1, 0, 1, 4'b1010);
        add(1, 0, 3, 4'b0010);
        add(0, 0, 6, 4'b0010);
        add(0, 0, 4, 4'b0000);

        reset   = 1'b1;
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            btn_inc = vecs[i].inc;
            btn_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), outs(), vecs[i].exp);
        end

        // async reset while pressed clears outputs before the next edge
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("held_level", outs(), 4'b0010);
        reset = 1'b1;
        #1;
        check("rst_async", outs(), 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        count_pulse("held_after_reset");

        // 6: reset mid-PRESS_WAIT with btn_inc still high
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_wait", outs(), 4'b0000);
        @(posedge clk);
        #1;
        check("rst_hold", outs(), 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        count_pulse("pulse_after_mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
